// File: rtl/cds_multi_strobe_generator.sv
// cds_multi_strobe_generator: trigger-started sequencer emitting per-channel delayed strobe pulses
module cds_multi_strobe_generator #(
  parameter int NUM_STROBES = 2,
  parameter int DELAY_WIDTH = 16,
  parameter int PW_WIDTH    = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             trigger,
  input  logic                             enable,
  input  logic [NUM_STROBES*DELAY_WIDTH-1:0] cds_delay,
  input  logic [NUM_STROBES*PW_WIDTH-1:0]    strobe_width,
  output logic [NUM_STROBES-1:0]           cds_strobe,
  output logic                             busy,
  output logic                             done,
  output logic                             overrun
);
  localparam int CW = DELAY_WIDTH + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic trigger_d, edge_det, last, start;
  logic [CW-1:0] count, end_max;
  logic [NUM_STROBES*DELAY_WIDTH-1:0] delay_q;
  logic [NUM_STROBES*PW_WIDTH-1:0] width_q;
  logic [CW-1:0] lo [NUM_STROBES];
  logic [CW-1:0] hi [NUM_STROBES];
  logic [NUM_STROBES-1:0] strobe_nx;
  for (genvar k = 0; k < NUM_STROBES; k++) begin : g_win
    assign lo[k] = {1'b0, delay_q[k*DELAY_WIDTH +: DELAY_WIDTH]};
    assign hi[k] = lo[k] + CW'(width_q[k*PW_WIDTH +: PW_WIDTH]);
    assign strobe_nx[k] = (count >= lo[k]) && (count < hi[k]);
  end
  // sequence length is the latest window end over all channels
  always_comb begin
    end_max = '0;
    for (int k = 0; k < NUM_STROBES; k++)
      end_max = (hi[k] > end_max) ? hi[k] : end_max;
  end
  // edge detect, completion and acceptance (back-to-back allowed on the completion cycle)
  always_comb begin
    edge_det = trigger & ~trigger_d;
    last     = (state == RUN) && (count == end_max);
    start    = edge_det && enable && ((state == IDLE) || last);
    state_nx = start ? RUN : (last ? IDLE : state);
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // datapath: latched config, cycle counter and registered outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      trigger_d  <= 1'b1;
      count      <= '0;
      delay_q    <= '0;
      width_q    <= '0;
      cds_strobe <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      trigger_d  <= trigger;
      delay_q    <= start ? cds_delay : delay_q;
      width_q    <= start ? strobe_width : width_q;
      count      <= (start || last) ? '0 : (state == RUN) ? count + CW'(1) : count;
      cds_strobe <= (state == RUN && !last) ? strobe_nx : '0;
      busy       <= (state_nx == RUN);
      done       <= last;
      overrun    <= edge_det && enable && (state == RUN) && !last;
    end
endmodule
